// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller:
// FSM encoding, register-index width and the all-zero bubble control word.
package hazard_ctrl_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

   localparam int REG_IDX_W = 5;
   localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic dmem_req;
      logic pc_hold;
      logic ifid_hold;
      logic idex_hold;
      logic exmem_hold;
      logic ifid_flush;
      logic idex_flush;
      logic memwb_bubble;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = 8'b0000_0000;

   function automatic logic reg_match(input logic used,
                                      input logic [REG_IDX_W-1:0] rs,
                                      input logic [REG_IDX_W-1:0] rd);
      return used & (rs == rd);
   endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: a load in EX writes a register that the
// instruction in ID actually reads (x0 never creates a dependency).
module load_use_detect
   import hazard_ctrl_pkg::*;
(
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_use_rs1,
   input  logic                 id_use_rs2,
   input  logic                 ex_MemRead,
   input  logic [REG_IDX_W-1:0] ex_rd,
   output logic                 load_use
);

   // dependency check against the EX destination
   always_comb begin
      load_use = 1'b0;
      if (ex_MemRead && (ex_rd != REG_ZERO)) begin
         load_use = reg_match(id_use_rs1, id_rs1, ex_rd) |
                    reg_match(id_use_rs2, id_rs2, ex_rd);
      end else begin
         load_use = 1'b0;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: memory-wait FSM, hold/flush/bubble decode,
// saturating stall/flush counters and a sticky memory-timeout flag.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_use_rs1,
   input  logic                 id_use_rs2,
   input  logic                 ex_MemRead,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic                 ex_branch_taken,
   input  logic                 mem_MemRead,
   input  logic                 mem_MemWrite,
   input  logic                 dmem_ack,
   output logic                 dmem_req,
   output logic                 pc_hold,
   output logic                 ifid_hold,
   output logic                 idex_hold,
   output logic                 exmem_hold,
   output logic                 ifid_flush,
   output logic                 idex_flush,
   output logic                 memwb_bubble,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt,
   output logic                 mem_err
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONES  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e            state_r, state_nxt_s;
   logic [WAIT_W-1:0] wait_cnt_r, wait_nxt_s;
   logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;
   logic              mem_err_r;
   logic              mem_acc_s, load_use_s;
   logic              stall_inc_s, flush_inc_s, timeout_s, eval_pipe_s;
   ctrl_t             ctrl_s, out_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_ONES) ? v : v + CNT_ONE;
   endfunction

   assign mem_acc_s = mem_MemRead | mem_MemWrite;

   load_use_detect u_lud (
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_use_rs1 (id_use_rs1),
      .id_use_rs2 (id_use_rs2),
      .ex_MemRead (ex_MemRead),
      .ex_rd      (ex_rd),
      .load_use   (load_use_s)
   );

   // next-state and control decode; memory stall outranks branch outranks load-use
   always_comb begin
      ctrl_s      = CTRL_BUBBLE;
      state_nxt_s = state_r;
      wait_nxt_s  = wait_cnt_r;
      stall_inc_s = 1'b0;
      flush_inc_s = 1'b0;
      timeout_s   = 1'b0;
      eval_pipe_s = 1'b0;
      case (state_r)
         RUN: begin
            ctrl_s.dmem_req = mem_acc_s;
            if (mem_acc_s && !dmem_ack) begin
               ctrl_s.pc_hold      = 1'b1;
               ctrl_s.ifid_hold    = 1'b1;
               ctrl_s.idex_hold    = 1'b1;
               ctrl_s.exmem_hold   = 1'b1;
               ctrl_s.memwb_bubble = 1'b1;
               stall_inc_s         = 1'b1;
               state_nxt_s         = MEM_WAIT;
               wait_nxt_s          = WAIT_ONE;
            end else begin
               eval_pipe_s = 1'b1;
            end
         end
         MEM_WAIT: begin
            ctrl_s.dmem_req = 1'b1;
            if (dmem_ack) begin
               eval_pipe_s = 1'b1;
               state_nxt_s = RUN;
               wait_nxt_s  = WAIT_ZERO;
            end else if (wait_cnt_r == WAIT_MAX) begin
               // abandon the access: MEM/WB gets a bubble, the rest may move
               ctrl_s.dmem_req     = 1'b0;
               ctrl_s.memwb_bubble = 1'b1;
               timeout_s           = 1'b1;
               eval_pipe_s         = 1'b1;
               state_nxt_s         = RUN;
               wait_nxt_s          = WAIT_ZERO;
            end else begin
               ctrl_s.pc_hold      = 1'b1;
               ctrl_s.ifid_hold    = 1'b1;
               ctrl_s.idex_hold    = 1'b1;
               ctrl_s.exmem_hold   = 1'b1;
               ctrl_s.memwb_bubble = 1'b1;
               stall_inc_s         = 1'b1;
               wait_nxt_s          = wait_cnt_r + WAIT_ONE;
            end
         end
         default: begin
            state_nxt_s = RUN;
            wait_nxt_s  = WAIT_ZERO;
         end
      endcase
      if (eval_pipe_s && ex_branch_taken) begin
         ctrl_s.ifid_flush = 1'b1;
         ctrl_s.idex_flush = 1'b1;
         flush_inc_s       = 1'b1;
      end else if (eval_pipe_s && load_use_s) begin
         ctrl_s.pc_hold    = 1'b1;
         ctrl_s.ifid_hold  = 1'b1;
         ctrl_s.idex_flush = 1'b1;
         stall_inc_s       = 1'b1;
      end else begin
         flush_inc_s = 1'b0;
      end
   end

   // outputs are forced quiet while reset is held
   always_comb begin
      out_s = CTRL_BUBBLE;
      if (rst) begin
         out_s = ctrl_s;
      end else begin
         out_s = CTRL_BUBBLE;
      end
   end

   // FSM state, wait counter, performance counters and sticky error
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= RUN;
         wait_cnt_r  <= WAIT_ZERO;
         stall_cnt_r <= CNT_ZERO;
         flush_cnt_r <= CNT_ZERO;
         mem_err_r   <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_nxt_s;
         if (stall_inc_s) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
         end
         if (flush_inc_s) begin
            flush_cnt_r <= sat_inc(flush_cnt_r);
         end
         if (timeout_s) begin
            mem_err_r <= 1'b1;
         end
      end
   end

   assign dmem_req     = out_s.dmem_req;
   assign pc_hold      = out_s.pc_hold;
   assign ifid_hold    = out_s.ifid_hold;
   assign idex_hold    = out_s.idex_hold;
   assign exmem_hold   = out_s.exmem_hold;
   assign ifid_flush   = out_s.ifid_flush;
   assign idex_flush   = out_s.idex_flush;
   assign memwb_bubble = out_s.memwb_bubble;
   assign stall_cnt    = stall_cnt_r;
   assign flush_cnt    = flush_cnt_r;
   assign mem_err      = mem_err_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares control outputs and counters.
module tb_hazard_ctrl;

   localparam logic [7:0] O_NONE = 8'b0000_0000;
   localparam logic [7:0] O_LU   = 8'b0110_0010;
   localparam logic [7:0] O_BR   = 8'b0000_0110;
   localparam logic [7:0] O_MST  = 8'b1111_1001;
   localparam logic [7:0] O_REQ  = 8'b1000_0000;
   localparam logic [7:0] O_RQBR = 8'b1000_0110;
   localparam logic [7:0] O_TO   = 8'b0000_0001;

   logic       clk, rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_use_rs1, id_use_rs2, ex_MemRead, ex_branch_taken;
   logic       mem_MemRead, mem_MemWrite, dmem_ack;
   logic       dmem_req, pc_hold, ifid_hold, idex_hold, exmem_hold;
   logic       ifid_flush, idex_flush, memwb_bubble, mem_err;
   logic [3:0] stall_cnt, flush_cnt;

   string      name_q[$];
   logic [7:0] out_q[$];
   logic [8:0] cnt_q[$];
   int         checks = 0;
   int         passes = 0;

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_MemRead(ex_MemRead), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
      .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .dmem_ack(dmem_ack),
      .dmem_req(dmem_req), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
      .idex_hold(idex_hold), .exmem_hold(exmem_hold),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // monitor: every negedge the controller presents one control word
   always @(negedge clk) begin : monitor
      string      nm;
      logic [7:0] eo, ao;
      logic [8:0] ec, ac;
      if (out_q.size() > 0) begin
         nm = name_q.pop_front();
         eo = out_q.pop_front();
         ec = cnt_q.pop_front();
         ao = {dmem_req, pc_hold, ifid_hold, idex_hold, exmem_hold,
               ifid_flush, idex_flush, memwb_bubble};
         ac = {stall_cnt, flush_cnt, mem_err};
         checks++;
         if (ao !== eo) $display("FAIL %s ctrl: got %b want %b", nm, ao, eo);
         else passes++;
         checks++;
         if (ac !== ec)
            $display("FAIL %s cnt: got stall=%0d flush=%0d err=%b want stall=%0d flush=%0d err=%b",
                     nm, ac[8:5], ac[4:1], ac[0], ec[8:5], ec[4:1], ec[0]);
         else passes++;
      end
   end

   task automatic cyc(input string nm, input logic [7:0] o, input logic [3:0] st,
                      input logic [3:0] fl, input logic er);
      name_q.push_back(nm);
      out_q.push_back(o);
      cnt_q.push_back({st, fl, er});
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_MemRead = 1'b0;
      ex_branch_taken = 1'b0; mem_MemRead = 1'b0; mem_MemWrite = 1'b0;
      dmem_ack = 1'b0;
   endtask

   task automatic set_load_use();
      ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
      id_rs1 = 5'd3; id_use_rs1 = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      @(posedge clk);
      #1;
      cyc("reset", O_NONE, 4'd0, 4'd0, 1'b0);
      rst = 1'b1;
      cyc("idle", O_NONE, 4'd0, 4'd0, 1'b0);

      // load-use on rs2, then x0 and rs1 variants
      set_load_use();
      cyc("lu", O_LU, 4'd0, 4'd0, 1'b0);
      clear_inputs();
      cyc("lu_done", O_NONE, 4'd1, 4'd0, 1'b0);
      ex_MemRead = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1; id_use_rs1 = 1'b1;
      cyc("lu_x0", O_NONE, 4'd1, 4'd0, 1'b0);
      ex_rd = 5'd7; id_rs1 = 5'd7;
      cyc("lu_rs1", O_LU, 4'd1, 4'd0, 1'b0);
      id_use_rs1 = 1'b0;
      cyc("lu_nouse", O_NONE, 4'd2, 4'd0, 1'b0);

      // branch beats load-use
      clear_inputs();
      set_load_use();
      ex_branch_taken = 1'b1;
      cyc("br_lu", O_BR, 4'd2, 4'd0, 1'b0);
      clear_inputs();
      cyc("br_done", O_NONE, 4'd2, 4'd1, 1'b0);

      // memory wait: three non-ack cycles, then ack
      mem_MemRead = 1'b1;
      cyc("mw0", O_MST, 4'd2, 4'd1, 1'b0);
      cyc("mw1", O_MST, 4'd3, 4'd1, 1'b0);
      cyc("mw2", O_MST, 4'd4, 4'd1, 1'b0);
      dmem_ack = 1'b1;
      cyc("mw_ack", O_REQ, 4'd5, 4'd1, 1'b0);
      clear_inputs();
      cyc("mw_done", O_NONE, 4'd5, 4'd1, 1'b0);
      mem_MemRead = 1'b1; dmem_ack = 1'b1;
      cyc("ack0", O_REQ, 4'd5, 4'd1, 1'b0);
      clear_inputs();
      cyc("ack0_done", O_NONE, 4'd5, 4'd1, 1'b0);

      // branch deferred across a memory stall
      mem_MemRead = 1'b1; ex_branch_taken = 1'b1;
      cyc("db0", O_MST, 4'd5, 4'd1, 1'b0);
      cyc("db1", O_MST, 4'd6, 4'd1, 1'b0);
      dmem_ack = 1'b1;
      cyc("db_ack", O_RQBR, 4'd7, 4'd1, 1'b0);
      clear_inputs();
      cyc("db_done", O_NONE, 4'd7, 4'd2, 1'b0);

      // timeout after four MEM_WAIT cycles
      mem_MemWrite = 1'b1;
      cyc("to0", O_MST, 4'd7, 4'd2, 1'b0);
      cyc("to1", O_MST, 4'd8, 4'd2, 1'b0);
      cyc("to2", O_MST, 4'd9, 4'd2, 1'b0);
      cyc("to3", O_MST, 4'd10, 4'd2, 1'b0);
      cyc("to_rel", O_TO, 4'd11, 4'd2, 1'b0);
      clear_inputs();
      dmem_ack = 1'b1;
      cyc("stray_ack", O_NONE, 4'd11, 4'd2, 1'b1);
      clear_inputs();
      set_load_use();
      cyc("err_lu", O_LU, 4'd11, 4'd2, 1'b1);
      clear_inputs();
      ex_branch_taken = 1'b1;
      cyc("err_br", O_BR, 4'd12, 4'd2, 1'b1);

      // stall counter saturation
      clear_inputs();
      set_load_use();
      for (int i = 0; i < 20; i++) begin
         cyc("sat", O_LU, (12 + i > 15) ? 4'd15 : 4'(12 + i), 4'd3, 1'b1);
      end
      clear_inputs();
      cyc("sat_done", O_NONE, 4'd15, 4'd3, 1'b1);

      // asynchronous reset in the middle of MEM_WAIT
      mem_MemRead = 1'b1;
      cyc("pre_rst", O_MST, 4'd15, 4'd3, 1'b1);
      rst = 1'b0;
      cyc("rst_mid", O_NONE, 4'd0, 4'd0, 1'b0);
      rst = 1'b1;
      clear_inputs();
      cyc("after_rst", O_NONE, 4'd0, 4'd0, 1'b0);
      mem_MemRead = 1'b1; dmem_ack = 1'b1;
      cyc("rst_run", O_REQ, 4'd0, 4'd0, 1'b0);
      clear_inputs();

      @(negedge clk);
      #1;
      checks++;
      if (out_q.size() != 0) $display("FAIL drain: got %0d pending want 0", out_q.size());
      else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
